// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one memory port between
// NUM_PORTS requesters. Each transaction runs IDLE -> BUSY -> RESP.
// The granted request is latched at grant time. The memory-side outputs
// come from that latched copy and stay stable until mem_resp arrives.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to add a BUSY watchdog.
// The watchdog ends a stalled transaction after TIMEOUT_CYCLES cycles and
// flags req_err for the granted port.
module mem_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int MASK_W        = DATA_W / 8,
  localparam int IDX_W         = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  input  logic [NUM_PORTS*MASK_W-1:0] req_byte_enable,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [NUM_PORTS-1:0]        req_err,
  output logic [DATA_W-1:0]           req_rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [MASK_W-1:0]           mem_byte_enable,
  input  logic                        mem_resp,
  input  logic [DATA_W-1:0]           mem_rdata
);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("mem_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       last_grant;
  logic [NUM_PORTS-1:0]   pending;
  logic                   found;
  logic [IDX_W-1:0]       next_idx;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]       busy_cnt;
`endif

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_PORTS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign pending = req_read | req_write;

  // Round-robin pick: first pending port after last_grant, wrapping around
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!found && pending[(int'(last_grant) + k) % NUM_PORTS]) begin
        found    = 1'b1;
        next_idx = IDX_W'((int'(last_grant) + k) % NUM_PORTS);
      end
    end
  end

  // Transaction FSM with registered memory-side and requester-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      grant_idx       <= '0;
      last_grant      <= IDX_W'(NUM_PORTS - 1);
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      req_resp        <= '0;
      req_err         <= '0;
      req_rdata       <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      busy_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_resp <= '0;
          req_err  <= '0;
          if (found) begin
            grant_idx       <= next_idx;
            last_grant      <= next_idx;
            mem_address     <= req_address[int'(next_idx)*ADDR_W +: ADDR_W];
            mem_wdata       <= req_wdata[int'(next_idx)*DATA_W +: DATA_W];
            mem_byte_enable <= req_byte_enable[int'(next_idx)*MASK_W +: MASK_W];
            // A simultaneous read and write resolves to the write
            mem_write       <= req_write[next_idx];
            mem_read        <= !req_write[next_idx];
`ifdef MEM_ARBITER_TIMEOUT_EN
            busy_cnt        <= '0;
`endif
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!mem_write) req_rdata <= mem_rdata;
            req_resp  <= port_onehot(grant_idx);
            state     <= RESP;
          end
`ifdef MEM_ARBITER_TIMEOUT_EN
          else if (busy_cnt == CNT_LAST) begin
            // Watchdog expiry: abandon the memory op and report an error
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            req_rdata <= '0;
            req_resp  <= port_onehot(grant_idx);
            req_err   <= port_onehot(grant_idx);
            state     <= RESP;
          end else begin
            busy_cnt  <= busy_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          // Completion pulse lasts one cycle; no arbitration here
          req_resp <= '0;
          req_err  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
